// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: registered one-hot grant, hold limit, one dead GAP cycle between owners.
// Latency: one cycle from sampled rqst to grant; no backpressure, requesters hold rqst until granted.
module bus_arbiter_rr #(
    parameter int drvrs    = 4,
    parameter int max_hold = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         rqst,
    input  logic [drvrs-1:0]         rls,
    output logic [drvrs-1:0]         bs_grnt,
    output logic [$clog2(drvrs)-1:0] grnt_id,
    output logic                     bs_bsy,
    output logic                     trn_chng,
    output logic                     tmout
);

    localparam int IDW = $clog2(drvrs);
    localparam int HW  = $clog2(max_hold);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [drvrs-1:0] bs_grnt_q, bs_grnt_d;
    logic [IDW-1:0]   grnt_id_q, grnt_id_d;
    logic             bs_bsy_q, bs_bsy_d;
    logic             trn_chng_q, trn_chng_d;
    logic             tmout_q, tmout_d;

    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand;
    logic             rel_c;
    logic             lim_c;

    // Scan from ptr upward (mod drvrs); the first requester found wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int i = 0; i < drvrs; i++) begin
            cand = IDW'((int'(ptr_q) + i) % drvrs);
            if (!win_vld && rqst[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    assign rel_c = rls[grnt_id_q] || !rqst[grnt_id_q];
    assign lim_c = (hold_cnt_q == HW'(max_hold - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        bs_grnt_d  = bs_grnt_q;
        grnt_id_d  = grnt_id_q;
        trn_chng_d = 1'b0;
        tmout_d    = 1'b0;

        case (state_q)
            GRANT: begin
                if (rel_c || lim_c) begin
                    state_d    = GAP;
                    bs_grnt_d  = '0;
                    trn_chng_d = 1'b1;
                    // A release coinciding with the limit is a normal release.
                    tmout_d    = lim_c && !rel_c;
                    ptr_d      = (grnt_id_q == IDW'(drvrs - 1)) ? '0 : grnt_id_q + 1'b1;
                end else if (!lim_c) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                if (win_vld) begin
                    state_d           = GRANT;
                    bs_grnt_d         = '0;
                    bs_grnt_d[win_id] = 1'b1;
                    grnt_id_d         = win_id;
                    hold_cnt_d        = '0;
                end else begin
                    state_d   = IDLE;
                    bs_grnt_d = '0;
                end
            end
        endcase

        bs_bsy_d = |bs_grnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            bs_grnt_q  <= '0;
            grnt_id_q  <= '0;
            bs_bsy_q   <= 1'b0;
            trn_chng_q <= 1'b0;
            tmout_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            bs_grnt_q  <= bs_grnt_d;
            grnt_id_q  <= grnt_id_d;
            bs_bsy_q   <= bs_bsy_d;
            trn_chng_q <= trn_chng_d;
            tmout_q    <= tmout_d;
        end
    end

    assign bs_grnt  = bs_grnt_q;
    assign grnt_id  = grnt_id_q;
    assign bs_bsy   = bs_bsy_q;
    assign trn_chng = trn_chng_q;
    assign tmout    = tmout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed checks of bus_arbiter_rr with four devices and a hold limit of six,
// followed by a random run under continuous one-hot / busy / gap / hold-length monitoring.
module tb_bus_arbiter_rr;

    localparam int D  = 4;
    localparam int MH = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic [D-1:0] rqst;
    logic [D-1:0] rls;
    logic [D-1:0] bs_grnt;
    logic [1:0]   grnt_id;
    logic         bs_bsy;
    logic         trn_chng;
    logic         tmout;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [D-1:0] prev_grnt = '0;
    int   own_len = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.drvrs(D), .max_hold(MH)) dut (
        .clk      (clk),
        .reset    (reset),
        .rqst     (rqst),
        .rls      (rls),
        .bs_grnt  (bs_grnt),
        .grnt_id  (grnt_id),
        .bs_bsy   (bs_bsy),
        .trn_chng (trn_chng),
        .tmout    (tmout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic bsy, input logic tc, input logic to);
        chk({tag, ".bs_grnt"}, 32'(bs_grnt), 32'(g));
        chk({tag, ".grnt_id"}, 32'(grnt_id), 32'(id));
        chk({tag, ".bs_bsy"}, 32'(bs_bsy), 32'(bsy));
        chk({tag, ".trn_chng"}, 32'(trn_chng), 32'(tc));
        chk({tag, ".tmout"}, 32'(tmout), 32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on every cycle once reset has taken effect.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon.onehot", 32'($countones(bs_grnt) <= 1), 32'd1);
            chk("mon.bsy", 32'(bs_bsy), 32'(|bs_grnt));
            if (prev_grnt != '0 && bs_grnt != '0)
                chk("mon.no_direct_switch", 32'(bs_grnt), 32'(prev_grnt));
            if (bs_grnt != '0) begin
                own_len = own_len + 1;
                chk("mon.hold_len_ok", 32'(own_len <= MH), 32'd1);
            end else begin
                own_len = 0;
            end
            prev_grnt = bs_grnt;
        end
    end

    initial begin
        // Reset with every input active: reset wins.
        reset = 1'b1;
        rqst  = 4'b1111;
        rls   = 4'b1111;
        tick();
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        rqst = 4'b1010;
        rls  = 4'b0000;
        tick();
        expect_out("reset_prio", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // Two persistent requesters: each owns for MH cycles, then times out.
        reset = 1'b0;
        for (int c = 0; c < MH; c++) begin
            tick();
            expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out("tmout1", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < MH; c++) begin
            tick();
            expect_out("own3", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out("tmout3", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1);
        tick();
        expect_out("own1_again", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);

        // Dropping rqst releases; rls while idle is ignored.
        rqst = 4'b0000;
        tick();
        expect_out("drop1", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
        rls = 4'b1111;
        tick();
        expect_out("idle", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("idle_rls", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0);

        // Single requester 0, released by rls after three grant cycles.
        rls  = 4'b0000;
        rqst = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out("own0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        rls = 4'b0001;
        tick();
        expect_out("rel0", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        rls  = 4'b0000;
        rqst = 4'b0011;
        tick();
        expect_out("ptr_after0", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);

        // All request; owner 1 releases, owner 2 ignores non-owner rls, then releases at the limit.
        rqst = 4'b1111;
        rls  = 4'b0010;
        tick();
        expect_out("rel1", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
        rls = 4'b0000;
        tick();
        expect_out("own2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c < MH; c++) begin
            rls = (c <= 3) ? 4'b0011 : 4'b0000;
            tick();
            expect_out("own2_ignore_rls", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
        end
        rls = 4'b0100;
        tick();
        expect_out("rel_at_limit", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
        rls = 4'b0000;
        tick();
        expect_out("own3b", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);

        // Owner 3 releases: pointer wraps to device 0.
        rls = 4'b1000;
        tick();
        expect_out("rel3", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
        rls = 4'b0000;
        tick();
        expect_out("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Non-owner rqst changes leave the ownership alone.
        rqst = 4'b0011;
        tick();
        expect_out("nonown_a", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        rqst = 4'b1101;
        tick();
        expect_out("nonown_b", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
        rqst = 4'b0010;
        tick();
        expect_out("drop0", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("own1c", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("own1d", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);

        // Reset mid-grant: silent drop, pointer back to 0.
        reset = 1'b1;
        rqst  = 4'b0011;
        tick();
        expect_out("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic; the monitor checks every cycle.
        for (int c = 0; c < 400; c++) begin
            rqst = D'($urandom_range(0, 15));
            rls  = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, 15)) : 4'b0000;
            tick();
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter drvrs, default 4, giving the number of bus devices (2..16).
REQ-002 The block SHALL have parameter max_hold, default 16, giving the maximum number of GRANT cycles per ownership (2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rqst, input, drvrs bits: bit i high means device i requests the bus.
REQ-006 The block SHALL have port rls, input, drvrs bits: bit i high means device i releases the bus this cycle.
REQ-007 The block SHALL have port bs_grnt, output, drvrs bits: one-hot registered grant; all zero when no device owns the bus.
REQ-008 The block SHALL have port grnt_id, output, $clog2(drvrs) bits: index of the current or most recent owner.
REQ-009 The block SHALL have port bs_bsy, output, 1 bit: high while any bs_grnt bit is high.
REQ-010 The block SHALL have port trn_chng, output, 1 bit: one-cycle pulse marking the end of an ownership.
REQ-011 The block SHALL have port tmout, output, 1 bit: one-cycle pulse marking an ownership that was ended by the hold limit.

Function
REQ-012 The FSM SHALL have the states IDLE, GRANT and GAP, and all outputs SHALL be registered.
REQ-013 The block SHALL keep a round-robin pointer ptr; device ptr has the highest priority, followed by ptr+1 and so on, modulo drvrs.
REQ-014 In IDLE with any rqst bit high, the winner SHALL be the first requesting device at or after ptr; the next state SHALL be GRANT, bs_grnt SHALL be one-hot for the winner, grnt_id SHALL equal the winner and hold_cnt SHALL be 0.
REQ-015 Latency SHALL be exactly one cycle: a rqst sampled in IDLE at edge n gives bs_grnt visible after edge n+1.
REQ-016 In IDLE with rqst all zero, the FSM SHALL stay in IDLE with bs_grnt at 0.
REQ-017 In GRANT, the release condition SHALL be rls[grnt_id] high or rqst[grnt_id] low.
REQ-018 In GRANT, the limit condition SHALL be hold_cnt equal to max_hold-1.
REQ-019 In GRANT, hold_cnt SHALL increment by 1 per cycle, saturating at max_hold-1.
REQ-020 On the release or limit condition, the next state SHALL be GAP, bs_grnt SHALL become 0 and trn_chng SHALL be 1 for the GAP cycle.
REQ-021 On the same transition, ptr SHALL become (grnt_id+1) mod drvrs, wrapping from drvrs-1 to 0.
REQ-022 tmout SHALL be 1 in the GAP cycle only when the limit condition held and the release condition did not; simultaneous release and limit SHALL count as a normal release with tmout at 0.
REQ-023 rls bits of non-owners SHALL be ignored in every state, and rls in IDLE or GAP SHALL have no effect.
REQ-024 GAP SHALL last exactly one cycle and SHALL arbitrate like IDLE: any rqst goes to GRANT, otherwise IDLE.
REQ-025 With this guaranteed dead cycle, two bs_grnt bits SHALL never be high in the same cycle, and bs_grnt SHALL never go directly from one owner to another.
REQ-026 In GAP, grnt_id SHALL hold the previous owner.
REQ-027 With a single persistent requester, the block SHALL re-grant that requester after each GAP.
REQ-028 rqst changes of non-owners during GRANT SHALL not affect the current ownership.

Reset
REQ-029 While reset is high at a clock edge, the block SHALL enter IDLE and set bs_grnt=0, grnt_id=0, bs_bsy=0, trn_chng=0, tmout=0, ptr=0 and hold_cnt=0.
REQ-030 Reset asserted during GRANT SHALL drop bs_grnt on the next edge, with no trn_chng or tmout pulse.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 After reset is released, arbitration SHALL start on the first edge with reset low.

Verification
REQ-033 Scenario: reset, then rqst=4'b1010 held -> grant order 1, gap, 3, gap, 1, each ownership max_hold cycles with tmout=1 in each gap.
REQ-034 Scenario: rqst=4'b0001 in IDLE at edge n, rls[0]=1 at edge n+3 -> bs_grnt=0001 after edges n+1..n+3; trn_chng=1 after edge n+4 with tmout=0; ptr=1.
REQ-035 Scenario: rqst=4'b1111 with owner 3 releasing -> ptr wraps to 0; next grant is device 0 after the GAP.
REQ-036 Scenario: owner 2 active, rls=4'b0011 (non-owners only) -> no change; rls[2] at hold_cnt=max_hold-1 -> trn_chng=1, tmout=0.
REQ-037 Scenario: reset pulsed mid-GRANT with owner 1 -> bs_grnt=0, trn_chng=0, ptr=0 after that edge; with rqst=4'b0011 afterwards, next grant is device 0.
REQ-038 Scenario: every cycle of a random rqst/rls run -> bs_grnt is one-hot or zero, bs_bsy equals the OR of bs_grnt, and a GAP separates every ownership.
